// File: rtl/fifo_cmd_sched_pkg.sv
// fifo_cmd_sched_pkg: modifier codes, FSM encoding and shared widths for the command scheduler and its bridge
package fifo_cmd_sched_pkg;
  localparam int WORD_W = 32;
  localparam int RSP_W = WORD_W + 2;
  localparam int WRF_DEFAULT = 3;
  localparam int S_IDLE = 0;
  localparam int S_POP = 1;
  localparam int S_TX_WAIT = 2;
  localparam int S_GAP = 3;
  typedef enum logic [1:0] {
    MOD_CONFIG  = 2'd0,
    MOD_DATA    = 2'd1,
    MOD_STATUS  = 2'd2,
    MOD_CHANNEL = 2'd3
  } mod_e;
  typedef enum logic [3:0] {
    IDLE    = 4'(1 << S_IDLE),
    POP     = 4'(1 << S_POP),
    TX_WAIT = 4'(1 << S_TX_WAIT),
    GAP     = 4'(1 << S_GAP)
  } state_e;
endpackage

// File: rtl/fifo_cmd_sched_if.sv
// fifo_cmd_sched_if: command/response FIFO and transceiver handshakes of the scheduler
interface fifo_cmd_sched_if import fifo_cmd_sched_pkg::*; ();
  logic cmd_empty;
  logic [RSP_W-1:0] cmd_data;
  logic cmd_inc;
  logic rsp_full;
  logic [RSP_W-1:0] rsp_data;
  logic rsp_inc;
  logic [WORD_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master (
    input  cmd_empty, cmd_data, rsp_full, tx_ready, rx_data, rx_valid,
    output cmd_inc, rsp_data, rsp_inc, tx_data, tx_valid, rx_ready
  );
  modport slave (
    output cmd_empty, cmd_data, rsp_full, tx_ready, rx_data, rx_valid,
    input  cmd_inc, rsp_data, rsp_inc, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/fifo_cmd_sched_rsp_arbiter.sv
// rsp_arbiter: merges echo, rx and status sources into the response FIFO, at most one push per two cycles
module rsp_arbiter import fifo_cmd_sched_pkg::*; #(
  parameter int CFG_W = 16,
  parameter int CHAN_W = 2,
  parameter int STAT_W = 16,
  parameter int WRF = WRF_DEFAULT
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic rsp_full,
  input  logic cfg_set,
  input  logic [CFG_W-1:0] cfg_val,
  input  logic chan_set,
  input  logic [CHAN_W-1:0] chan_val,
  input  logic rx_valid,
  input  logic [WORD_W-1:0] rx_data,
  output logic rx_ready,
  input  logic [STAT_W-1:0] stat_in,
  output logic [RSP_W-1:0] rsp_data,
  output logic rsp_inc
);
  logic cfg_pend, chan_pend, rr, wrf_seen, stat_pend, open;
  logic g_cfg, g_chan, g_rx, g_st;
  logic [STAT_W-1:0] snap, stat_v;
  // Grant: echoes first, then rx/status alternating via rr (0 favours rx)
  always_comb begin
    open = !rsp_full && !rsp_inc;
    stat_pend = stat_in != snap;
    g_cfg = open && cfg_pend;
    g_chan = open && !cfg_pend && chan_pend;
    g_rx = open && !cfg_pend && !chan_pend && rx_valid && (!rr || !stat_pend);
    g_st = open && !cfg_pend && !chan_pend && stat_pend && (rr || !rx_valid);
    stat_v = stat_in;
    stat_v[WRF] = stat_in[WRF] | wrf_seen;
  end
  assign rx_ready = g_rx;
  // Pending flags, rr pointer and the registered push; the snapshot keeps raw stat_in so a forced WRF bit never retriggers
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cfg_pend <= 1'b0;
      chan_pend <= 1'b0;
      rr <= 1'b0;
      wrf_seen <= 1'b0;
      snap <= '0;
      rsp_inc <= 1'b0;
      rsp_data <= '0;
    end else begin
      cfg_pend <= (cfg_pend | cfg_set) & ~g_cfg;
      chan_pend <= (chan_pend | chan_set) & ~g_chan;
      rsp_inc <= g_cfg | g_chan | g_rx | g_st;
      if (g_rx || g_st) rr <= ~rr;
      if (g_rx) wrf_seen <= 1'b1;
      else if (g_st) wrf_seen <= 1'b0;
      if (g_st) snap <= stat_in;
      rsp_data <= g_cfg ? {MOD_CONFIG, WORD_W'(cfg_val)} :
                  g_chan ? {MOD_CHANNEL, WORD_W'(chan_val)} :
                  g_rx ? {MOD_DATA, rx_data} :
                  g_st ? {MOD_STATUS, WORD_W'(stat_v)} : rsp_data;
    end
  end
endmodule

// File: rtl/fifo_cmd_sched.sv
// fifo_cmd_sched: pops commands from a FWFT FIFO, applies config/channel/tx, and feeds responses back
module fifo_cmd_sched import fifo_cmd_sched_pkg::*; #(
  parameter int CFG_W = 16,
  parameter int CHAN_W = 2,
  parameter int STAT_W = 16,
  parameter int WRF = WRF_DEFAULT
) (
  input  logic pclk,
  input  logic preset_n,
  fifo_cmd_sched_if.master bus,
  output logic [CFG_W-1:0] cfg_o,
  output logic cfg_we,
  output logic [CHAN_W-1:0] chan_o,
  input  logic [STAT_W-1:0] stat_in
);
  state_e state;
  logic chan_we;
  // Command FSM: one pop per IDLE-POP-GAP round, DATA parks in TX_WAIT until the handshake
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= IDLE;
      bus.cmd_inc <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data <= '0;
      cfg_o <= '0;
      cfg_we <= 1'b0;
      chan_o <= '0;
      chan_we <= 1'b0;
    end else begin
      bus.cmd_inc <= 1'b0;
      cfg_we <= 1'b0;
      chan_we <= 1'b0;
      case (state)
        IDLE: if (!bus.cmd_empty) begin
          state <= POP;
          bus.cmd_inc <= 1'b1;
        end
        POP: begin
          state <= GAP;
          case (mod_e'(bus.cmd_data[RSP_W-1:WORD_W]))
            MOD_CONFIG: begin
              cfg_o <= bus.cmd_data[CFG_W-1:0];
              cfg_we <= 1'b1;
            end
            MOD_CHANNEL: begin
              chan_o <= bus.cmd_data[CHAN_W-1:0];
              chan_we <= 1'b1;
            end
            MOD_DATA: begin
              bus.tx_data <= bus.cmd_data[WORD_W-1:0];
              bus.tx_valid <= 1'b1;
              state <= TX_WAIT;
            end
            default: ;
          endcase
        end
        TX_WAIT: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          state <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  rsp_arbiter #(.CFG_W(CFG_W), .CHAN_W(CHAN_W), .STAT_W(STAT_W), .WRF(WRF)) u_arb (
    .pclk(pclk),
    .preset_n(preset_n),
    .rsp_full(bus.rsp_full),
    .cfg_set(cfg_we),
    .cfg_val(cfg_o),
    .chan_set(chan_we),
    .chan_val(chan_o),
    .rx_valid(bus.rx_valid),
    .rx_data(bus.rx_data),
    .rx_ready(bus.rx_ready),
    .stat_in(stat_in),
    .rsp_data(bus.rsp_data),
    .rsp_inc(bus.rsp_inc)
  );
endmodule

// File: tb/tb_fifo_cmd_sched.sv
// tb_fifo_cmd_sched: scoreboard bench for the command scheduler and response arbiter
module tb_fifo_cmd_sched;
  import fifo_cmd_sched_pkg::*;
  logic pclk, preset_n, cfg_we;
  logic [15:0] cfg_o, stat_in;
  logic [1:0] chan_o;
  int n_cmp = 0, n_err = 0, cyc = 0, base;
  logic [33:0] exp_q[$];
  int push_cyc[$];
  fifo_cmd_sched_if bus();
  fifo_cmd_sched dut (
    .pclk(pclk), .preset_n(preset_n), .bus(bus),
    .cfg_o(cfg_o), .cfg_we(cfg_we), .chan_o(chan_o), .stat_in(stat_in)
  );
  initial pclk = 0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge pclk) if (preset_n && bus.rsp_inc) begin
    push_cyc.push_back(cyc);
    if (exp_q.size() == 0) chk("rsp_extra", {30'd0, bus.rsp_data}, 64'h0);
    else chk("rsp", {30'd0, bus.rsp_data}, {30'd0, exp_q.pop_front()});
  end
  task automatic set_cmd(input logic [1:0] m, input logic [31:0] p);
    bus.cmd_data = {m, p};
    bus.cmd_empty = 0;
  endtask
  task automatic wait_pop(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (bus.cmd_inc) begin seen = 1; break; end
    end
    chk({tag, "_pop"}, 64'(seen), 1);
    @(posedge pclk); #1 bus.cmd_empty = 1;
  endtask
  task automatic rx_take(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (bus.rx_ready) begin seen = 1; break; end
    end
    chk({tag, "_rx_ready"}, 64'(seen), 1);
    @(posedge pclk); #1 bus.rx_valid = 0;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge pclk); #1;
    end
    chk({tag, "_drain"}, 64'(exp_q.size()), 0);
  endtask
  function automatic int gap(input int i);
    return (push_cyc.size() > i + 1) ? push_cyc[i+1] - push_cyc[i] : -1;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    preset_n = 0; stat_in = 0;
    bus.cmd_empty = 1; bus.cmd_data = 0; bus.rsp_full = 0;
    bus.tx_ready = 0; bus.rx_data = 0; bus.rx_valid = 0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_cfg", 64'(cfg_o), 0);
    chk("rst_txv", 64'(bus.tx_valid), 0);
    chk("rst_rsp", 64'(bus.rsp_inc), 0);
    preset_n = 1;
    @(posedge pclk); #1;
    // config command and its echo
    set_cmd(MOD_CONFIG, 32'h0000A5A5);
    exp_q.push_back({MOD_CONFIG, 32'h0000A5A5});
    wait_pop("cfg");
    @(negedge pclk);
    chk("cfg_inc_1cyc", 64'(bus.cmd_inc), 0);
    chk("cfg_we", 64'(cfg_we), 1);
    chk("cfg_o", 64'(cfg_o), 64'hA5A5);
    @(negedge pclk);
    chk("cfg_we_pulse", 64'(cfg_we), 0);
    drain("cfg");
    // data held while tx_ready low, next command waits for the handshake
    @(posedge pclk); #1;
    set_cmd(MOD_DATA, 32'hDEADBEEF);
    wait_pop("data");
    set_cmd(MOD_CHANNEL, 32'h2);
    exp_q.push_back({MOD_CHANNEL, 32'h2});
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("tx_hold_valid", 64'(bus.tx_valid), 1);
      chk("tx_hold_data", 64'(bus.tx_data), 64'hDEADBEEF);
      chk("tx_hold_noinc", 64'(bus.cmd_inc), 0);
    end
    @(posedge pclk); #1 bus.tx_ready = 1;
    @(negedge pclk);
    chk("tx_hs_valid", 64'(bus.tx_valid), 1);
    @(posedge pclk); #1 bus.tx_ready = 0;
    @(negedge pclk);
    chk("tx_done", 64'(bus.tx_valid), 0);
    wait_pop("chan");
    @(negedge pclk);
    chk("chan_o", 64'(chan_o), 2);
    drain("chan");
    // status command is dropped silently
    base = push_cyc.size();
    @(posedge pclk); #1;
    set_cmd(MOD_STATUS, 32'h000000FF);
    wait_pop("stcmd");
    repeat (6) @(negedge pclk);
    chk("stcmd_cfg", 64'(cfg_o), 64'hA5A5);
    chk("stcmd_chan", 64'(chan_o), 2);
    chk("stcmd_norsp", 64'(push_cyc.size()), 64'(base));
    // rx and status change together: rx first, status two cycles later with WRF
    @(posedge pclk); #1;
    bus.rx_valid = 1; bus.rx_data = 32'h12345678; stat_in = 16'h0001;
    exp_q.push_back({MOD_DATA, 32'h12345678});
    exp_q.push_back({MOD_STATUS, 32'h00000009});
    base = push_cyc.size();
    rx_take("rxst");
    drain("rxst");
    chk("rxst_gap", 64'(gap(base)), 2);
    // full stalls everything; release drains config, rx, status in order
    @(posedge pclk); #1;
    bus.rsp_full = 1; stat_in = 16'h0002;
    bus.rx_valid = 1; bus.rx_data = 32'hCAFEF00D;
    set_cmd(MOD_CONFIG, 32'h00001234);
    wait_pop("full_cfg");
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      chk("full_noinc", 64'(bus.rsp_inc), 0);
      chk("full_norx", 64'(bus.rx_ready), 0);
    end
    exp_q.push_back({MOD_CONFIG, 32'h00001234});
    exp_q.push_back({MOD_DATA, 32'hCAFEF00D});
    exp_q.push_back({MOD_STATUS, 32'h0000000A});
    base = push_cyc.size();
    @(posedge pclk); #1 bus.rsp_full = 0;
    rx_take("full");
    drain("full");
    chk("full_gap0", 64'(gap(base)), 2);
    chk("full_gap1", 64'(gap(base + 1)), 2);
    // reset in TX_WAIT, then status push from the cleared snapshot and a fresh command
    @(posedge pclk); #1;
    set_cmd(MOD_DATA, 32'h00000011);
    wait_pop("rst_data");
    @(negedge pclk);
    chk("rst_txv_pre", 64'(bus.tx_valid), 1);
    #1 preset_n = 0;
    #1;
    chk("rst_mid_txv", 64'(bus.tx_valid), 0);
    chk("rst_mid_cfg", 64'(cfg_o), 0);
    chk("rst_mid_chan", 64'(chan_o), 0);
    chk("rst_mid_state", 64'(dut.state), 1);
    exp_q.push_back({MOD_STATUS, 32'h00000002});
    exp_q.push_back({MOD_CONFIG, 32'h000000FF});
    @(posedge pclk); #1 preset_n = 1;
    @(posedge pclk); #1;
    set_cmd(MOD_CONFIG, 32'h000000FF);
    wait_pop("post_rst");
    @(negedge pclk);
    chk("post_rst_cfg", 64'(cfg_o), 64'hFF);
    chk("post_rst_we", 64'(cfg_we), 1);
    drain("post_rst");
    repeat (4) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
